pc_gen: RTL and testbench



---
 rtl/cpu_pkg.sv | 27 ++
 rtl/irq_sync.sv | 43 ++++
 rtl/pc_gen.sv | 124 ++++++++++++
 tb/tb_pc_gen.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: PC width, reset/vector defaults and the
// next-PC source encoding used by the fetch redirect logic.
package cpu_pkg;

  localparam int unsigned PC_W = 32;

  localparam logic [PC_W-1:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [PC_W-1:0] DEF_EXC_VECTOR = 32'h8000_0004;
  localparam logic [PC_W-1:0] DEF_IRQ_VECTOR = 32'h8000_0008;

  // Source of the next fetch address.
  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_HOLD,
    SEL_JUMP,
    SEL_JR,
    SEL_BR,
    SEL_IRQ,
    SEL_EXC
  } pc_sel_e;

  // Sequential successor; wraps modulo 2^32.
  function automatic logic [PC_W-1:0] pc_incr(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction

endpackage

// File: rtl/irq_sync.sv
// External interrupt front end: two-flop synchroniser, rising-edge detect
// and a pending latch that holds the request until the pipeline takes it.
module irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic take,
  output logic pending
);

  logic [1:0] sync_q;
  logic       dly_q;
  logic       pending_q;
  logic       pending_d;
  logic       rise;

  // Synchroniser, edge-detect delay and pending state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= 2'b00;
      dly_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], irq};
      dly_q     <= sync_q[1];
      pending_q <= pending_d;
    end
  end

  // Take has priority so a request is never serviced twice.
  always_comb begin
    rise      = sync_q[1] & ~dly_q;
    pending_d = pending_q;
    if (take) begin
      pending_d = 1'b0;
    end else if (rise) begin
      pending_d = 1'b1;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/pc_gen.sv
// Next-PC generator and redirect controller. Picks the next fetch address
// from sequential flow, stall, jumps, branches, exceptions and interrupts,
// tracks the PC held in fetch and records the exception return address.
module pc_gen
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [PC_W-1:0] EXC_VECTOR = DEF_EXC_VECTOR,
  parameter logic [PC_W-1:0] IRQ_VECTOR = DEF_IRQ_VECTOR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            jr,
  input  logic [PC_W-1:0] jr_target,
  input  logic            exception,
  input  logic [PC_W-1:0] id_pc,
  input  logic            irq,
  output logic [PC_W-1:0] PC,
  output logic [PC_W-1:0] pc_cur,
  output logic [PC_W-1:0] epc,
  output logic            kernel,
  output logic            flush_if_id,
  output logic            flush_id_ex
);

  logic [PC_W-1:0] pc_cur_q;
  logic [PC_W-1:0] epc_q;
  logic [PC_W-1:0] epc_d;
  logic [PC_W-1:0] pc_next;
  logic            irq_pending;
  logic            irq_take;
  pc_sel_e         sel;

  assign kernel = pc_cur_q[PC_W-1];

  // Interrupts wait for user mode and a cycle free of any other redirect or stall.
  assign irq_take = irq_pending & ~kernel & ~stall & ~branch_taken & ~jump & ~jr & ~exception;

  irq_sync u_irq_sync (
    .clk     (clk),
    .reset   (reset),
    .irq     (irq),
    .take    (irq_take),
    .pending (irq_pending)
  );

  // Priority select of the next-PC source; any redirect overrides stall.
  always_comb begin
    sel = SEL_SEQ;
    if (exception) begin
      sel = SEL_EXC;
    end else if (branch_taken) begin
      sel = SEL_BR;
    end else if (irq_take) begin
      sel = SEL_IRQ;
    end else if (jr) begin
      sel = SEL_JR;
    end else if (jump) begin
      sel = SEL_JUMP;
    end else if (stall) begin
      sel = SEL_HOLD;
    end
  end

  // Next-PC mux; forced to the reset PC while reset is held.
  always_comb begin
    pc_next = pc_cur_q;
    if (reset) begin
      pc_next = RESET_PC;
    end else begin
      unique case (sel)
        SEL_EXC:  pc_next = EXC_VECTOR;
        SEL_BR:   pc_next = branch_target;
        SEL_IRQ:  pc_next = IRQ_VECTOR;
        SEL_JR:   pc_next = jr_target;
        SEL_JUMP: pc_next = jump_target;
        SEL_HOLD: pc_next = pc_cur_q;
        SEL_SEQ:  pc_next = pc_incr(pc_cur_q);
        default:  pc_next = pc_cur_q;
      endcase
    end
  end

  // Flushes: IF/ID on any redirect, ID/EX only when the ID instruction itself dies.
  always_comb begin
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (!reset) begin
      flush_if_id = exception | branch_taken | irq_take | jr | jump;
      flush_id_ex = exception | branch_taken;
    end
  end

  // EPC capture: faulting ID PC on exception, squashed fetch PC on interrupt.
  always_comb begin
    epc_d = epc_q;
    if (exception) begin
      epc_d = id_pc;
    end else if (irq_take) begin
      epc_d = pc_cur_q;
    end
  end

  // PC mirror of the fetch latch and EPC register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_cur_q <= RESET_PC;
      epc_q    <= '0;
    end else begin
      pc_cur_q <= pc_next;
      epc_q    <= epc_d;
    end
  end

  assign PC     = pc_next;
  assign pc_cur = pc_cur_q;
  assign epc    = epc_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed vector table, hand-written interrupt/reset
// sequences and a randomized run against a behavioural model.
module tb_pc_gen;

  localparam logic [31:0] EXC_V = 32'h8000_0004;
  localparam logic [31:0] IRQ_V = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branch_taken, jump, jr, exception, irq;
  logic [31:0] branch_target, jump_target, jr_target, id_pc;
  logic [31:0] PC, pc_cur, epc;
  logic        kernel, flush_if_id, flush_id_ex;

  int checks = 0;
  int errors = 0;

  pc_gen dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_target     (jr_target),
    .exception     (exception),
    .id_pc         (id_pc),
    .irq           (irq),
    .PC            (PC),
    .pc_cur        (pc_cur),
    .epc           (epc),
    .kernel        (kernel),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        s;
    logic        b;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt;
    logic        r;
    logic [31:0] rt;
    logic        e;
    logic [31:0] ip;
    logic [31:0] e_pc;
    logic        e_fif;
    logic        e_fie;
    logic [31:0] e_cur;
    logic [31:0] e_epc;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic s, input logic b, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt, input logic r,
                              input logic [31:0] rt, input logic e, input logic [31:0] ip,
                              input logic [31:0] e_pc, input logic e_fif, input logic e_fie,
                              input logic [31:0] e_cur, input logic [31:0] e_epc);
    vec_t v;
    v.s = s; v.b = b; v.bt = bt; v.j = j; v.jt = jt; v.r = r; v.rt = rt;
    v.e = e; v.ip = ip; v.e_pc = e_pc; v.e_fif = e_fif; v.e_fie = e_fie;
    v.e_cur = e_cur; v.e_epc = e_epc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_in();
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; jr = 1'b0; exception = 1'b0;
    branch_target = '0; jump_target = '0; jr_target = '0; id_pc = '0;
  endtask

  // Advance to 1 time unit after the next rising edge (input drive point).
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Check PC and flushes at mid-cycle.
  task automatic chk_pc(input string name, input logic [31:0] e_pc, input logic fif,
                        input logic fie);
    #4;
    chk({name, ".PC"}, PC, e_pc);
    chk({name, ".fif"}, 32'(flush_if_id), 32'(fif));
    chk({name, ".fie"}, 32'(flush_id_ex), 32'(fie));
  endtask

  // Behavioural model state for the random phase.
  logic [31:0] m_cur, m_epc;
  logic        m_pend;
  logic [2:0]  m_hist;   // irq as sampled at the last three edges, [0] newest

  initial begin
    logic [31:0] e_pc;
    logic        take, fif, fie, kern;

    idle_in();
    irq   = 1'b0;
    reset = 1'b1;
    // Reset overrides an asserted branch.
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0999;
    #3;
    chk("rst.PC", PC, 32'h0);
    chk("rst.fif", 32'(flush_if_id), 32'h0);
    chk("rst.fie", 32'(flush_id_ex), 32'h0);
    chk("rst.cur", pc_cur, 32'h0);
    chk("rst.epc", epc, 32'h0);
    chk("rst.kernel", 32'(kernel), 32'h0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    idle_in();

    // ---------------- Directed vector table ----------------
    tbl[0]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 32'h0,
                 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
    tbl[1]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 32'h0,
                 32'h8, 1'b0, 1'b0, 32'h4, 32'h0);
    tbl[2]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 32'h0,
                 32'hC, 1'b0, 1'b0, 32'h8, 32'h0);
    tbl[3]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h40,  1'b0, 32'h0, 1'b0, 32'h0,
                 32'h40, 1'b1, 1'b0, 32'hC, 32'h0);
    tbl[4]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 32'h0,
                 32'h40, 1'b0, 1'b0, 32'h40, 32'h0);
    tbl[5]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 32'h0,
                 32'h40, 1'b0, 1'b0, 32'h40, 32'h0);
    tbl[6]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 32'h0,
                 32'h44, 1'b0, 1'b0, 32'h40, 32'h0);
    tbl[7]  = mk(1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 32'h0,
                 32'h100, 1'b1, 1'b1, 32'h44, 32'h0);
    tbl[8]  = mk(1'b0, 1'b1, 32'h300, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 32'h0,
                 32'h300, 1'b1, 1'b1, 32'h100, 32'h0);
    tbl[9]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h600, 1'b1, 32'h500, 1'b0, 32'h0,
                 32'h500, 1'b1, 1'b0, 32'h300, 32'h0);
    tbl[10] = mk(1'b1, 1'b1, 32'h300, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h24,
                 EXC_V, 1'b1, 1'b1, 32'h500, 32'h0);
    tbl[11] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 32'h0,
                 32'h8000_0008, 1'b0, 1'b0, EXC_V, 32'h24);
    tbl[12] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,
                 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h8000_0008, 32'h24);
    tbl[13] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 32'h0,
                 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h24);
    tbl[14] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h1233, 1'b0, 32'h0, 1'b0, 32'h0,
                 32'h1233, 1'b1, 1'b0, 32'h0, 32'h24);

    for (int i = 0; i < 15; i++) begin
      stall = tbl[i].s; branch_taken = tbl[i].b; branch_target = tbl[i].bt;
      jump = tbl[i].j; jump_target = tbl[i].jt; jr = tbl[i].r; jr_target = tbl[i].rt;
      exception = tbl[i].e; id_pc = tbl[i].ip;
      chk_pc($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_fif, tbl[i].e_fie);
      chk($sformatf("vec%0d.cur", i), pc_cur, tbl[i].e_cur);
      chk($sformatf("vec%0d.epc", i), epc, tbl[i].e_epc);
      chk($sformatf("vec%0d.kernel", i), 32'(kernel), 32'(tbl[i].e_cur[31]));
      next_cycle();
    end
    idle_in();

    // ---------------- Interrupt taken in user mode ----------------
    jump = 1'b1; jump_target = 32'h50;
    chk_pc("irq.jmp", 32'h50, 1'b1, 1'b0);
    next_cycle();
    idle_in();
    irq = 1'b1;                                   // one-cycle pulse
    chk_pc("irq.a", 32'h54, 1'b0, 1'b0);
    next_cycle();
    irq = 1'b0;
    chk_pc("irq.b", 32'h58, 1'b0, 1'b0);
    next_cycle();
    chk_pc("irq.c", 32'h5C, 1'b0, 1'b0);
    next_cycle();
    chk_pc("irq.take", IRQ_V, 1'b1, 1'b0);
    next_cycle();
    chk_pc("irq.after", 32'h8000_000C, 1'b0, 1'b0);
    chk("irq.epc", epc, 32'h5C);
    chk("irq.cur", pc_cur, IRQ_V);
    chk("irq.kernel", 32'(kernel), 32'h1);
    next_cycle();

    // ---------------- Interrupt deferred in kernel mode ----------------
    irq = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk_pc($sformatf("kdef%0d", k), 32'h8000_0010 + 32'(4 * k), 1'b0, 1'b0);
      next_cycle();
      irq = 1'b0;
    end
    jr = 1'b1; jr_target = 32'h60;
    chk_pc("kdef.jr", 32'h60, 1'b1, 1'b0);
    next_cycle();
    idle_in();
    chk_pc("kdef.take", IRQ_V, 1'b1, 1'b0);
    next_cycle();
    chk("kdef.epc", epc, 32'h60);
    chk_pc("kdef.after", 32'h8000_000C, 1'b0, 1'b0);
    next_cycle();

    // ---------------- Asynchronous reset with interrupt pending ----------------
    irq = 1'b1;
    next_cycle();
    irq = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    #2;
    reset = 1'b1;
    #1;
    chk("arst.PC", PC, 32'h0);
    chk("arst.cur", pc_cur, 32'h0);
    chk("arst.epc", epc, 32'h0);
    chk("arst.fif", 32'(flush_if_id), 32'h0);
    next_cycle();
    reset = 1'b0;
    chk_pc("arst.r0", 32'h4, 1'b0, 1'b0);
    chk("arst.r0cur", pc_cur, 32'h0);
    next_cycle();
    chk_pc("arst.r1", 32'h8, 1'b0, 1'b0);
    next_cycle();
    chk_pc("arst.r2", 32'hC, 1'b0, 1'b0);
    next_cycle();

    // ---------------- Randomized run against the model ----------------
    reset = 1'b1;
    m_cur = 32'h0; m_epc = 32'h0; m_pend = 1'b0; m_hist = 3'b000;
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 500; c++) begin
      reset        = ($urandom_range(59) == 0);
      stall        = ($urandom_range(3) == 0);
      branch_taken = ($urandom_range(7) == 0);
      jump         = ($urandom_range(7) == 0);
      jr           = ($urandom_range(9) == 0);
      exception    = ($urandom_range(15) == 0);
      if ($urandom_range(4) == 0) irq = ~irq;
      branch_target = $urandom;
      jump_target   = $urandom;
      jr_target     = $urandom;
      id_pc         = $urandom;
      if ($urandom_range(3) != 0) branch_target[31] = 1'b0;
      if ($urandom_range(3) != 0) jump_target[31] = 1'b0;
      if ($urandom_range(3) != 0) jr_target[31] = 1'b0;
      if (reset) begin
        m_cur = 32'h0; m_epc = 32'h0; m_pend = 1'b0; m_hist = 3'b000;
      end
      #4;
      kern = m_cur[31];
      take = !reset && m_pend && !kern && !stall && !branch_taken && !jump && !jr
             && !exception;
      if (reset)             e_pc = 32'h0;
      else if (exception)    e_pc = EXC_V;
      else if (branch_taken) e_pc = branch_target;
      else if (take)         e_pc = IRQ_V;
      else if (jr)           e_pc = jr_target;
      else if (jump)         e_pc = jump_target;
      else if (stall)        e_pc = m_cur;
      else                   e_pc = m_cur + 32'd4;
      fif = !reset && (exception || branch_taken || take || jr || jump);
      fie = !reset && (exception || branch_taken);
      chk("rnd.PC", PC, e_pc);
      chk("rnd.fif", 32'(flush_if_id), 32'(fif));
      chk("rnd.fie", 32'(flush_id_ex), 32'(fie));
      chk("rnd.cur", pc_cur, m_cur);
      chk("rnd.epc", epc, m_epc);
      chk("rnd.kernel", 32'(kernel), 32'(kern));
      @(posedge clk);
      if (reset) begin
        m_cur = 32'h0; m_epc = 32'h0; m_pend = 1'b0; m_hist = 3'b000;
      end else begin
        if (exception) m_epc = id_pc;
        else if (take) m_epc = m_cur;
        if (take) m_pend = 1'b0;
        else if (m_hist[1] && !m_hist[2]) m_pend = 1'b1;
        m_hist = {m_hist[1:0], irq};
        m_cur  = e_pc;
      end
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
